// File: rtl/vga_driver_if.sv
// Pixel bus between the SVGA timing generator and the colour generator:
// coordinate request out, registered colour back, VGA pins out.
interface vga_driver_if;
  localparam int unsigned COORD_W = 11;
  localparam int unsigned RGB_W   = 16;

  logic [RGB_W-1:0]   pixel_data;
  logic [COORD_W-1:0] pixel_xpos;
  logic [COORD_W-1:0] pixel_ypos;
  logic               data_req;
  logic               vga_hs;
  logic               vga_vs;
  logic               vga_en;
  logic [RGB_W-1:0]   vga_rgb;
  logic               frame_start;

  // Timing generator side
  modport master (
    input  pixel_data,
    output pixel_xpos, pixel_ypos, data_req,
    output vga_hs, vga_vs, vga_en, vga_rgb, frame_start
  );

  // Colour generator / display side
  modport slave (
    output pixel_data,
    input  pixel_xpos, pixel_ypos, data_req,
    input  vga_hs, vga_vs, vga_en, vga_rgb, frame_start
  );
endinterface

// File: rtl/vga_driver.sv
// SVGA raster timing generator: h/v counters, syncs, active-video gating and
// a coordinate request issued one cycle ahead of display.
module vga_driver #(
  parameter logic [10:0] H_SYNC   = 11'd128,
  parameter logic [10:0] H_BACK   = 11'd88,
  parameter logic [10:0] H_DISP   = 11'd800,
  parameter logic [10:0] H_FRONT  = 11'd40,
  parameter logic [10:0] H_TOTAL  = 11'd1056,
  parameter logic [10:0] V_SYNC   = 11'd4,
  parameter logic [10:0] V_BACK   = 11'd23,
  parameter logic [10:0] V_DISP   = 11'd600,
  parameter logic [10:0] V_FRONT  = 11'd1,
  parameter logic [10:0] V_TOTAL  = 11'd628,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic         vga_clk,
  input  logic         sys_rst,
  vga_driver_if.master bus
);
  localparam int unsigned CNT_W = 11;
  localparam int unsigned RGB_W = 16;

  localparam logic [CNT_W-1:0] HA     = H_SYNC + H_BACK;
  localparam logic [CNT_W-1:0] VA     = V_SYNC + V_BACK;
  localparam logic [CNT_W-1:0] HA_END = HA + H_DISP;
  localparam logic [CNT_W-1:0] VA_END = VA + V_DISP;
  localparam logic [CNT_W-1:0] REQ_LO = HA - CNT_W'(1);
  localparam logic [CNT_W-1:0] REQ_HI = HA_END - CNT_W'(1);

  // Front porch only pads the line/frame; totals carry it implicitly.
  localparam logic [CNT_W-1:0] H_FRONT_UNUSED = H_FRONT;
  localparam logic [CNT_W-1:0] V_FRONT_UNUSED = V_FRONT;

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             r_frame_start;

  logic             w_h_last;
  logic             w_v_last;
  logic             w_row_act;
  logic             w_en;
  logic             w_req;

  assign w_h_last = (r_h_cnt == H_TOTAL - CNT_W'(1));
  assign w_v_last = (r_v_cnt == V_TOTAL - CNT_W'(1));

  // Raster counters; reset restarts the frame at once
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_h_cnt       <= w_h_last ? '0 : r_h_cnt + CNT_W'(1);
      if (w_h_last) begin
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
      end
      r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
    end
  end

  assign w_row_act = (r_v_cnt >= VA) && (r_v_cnt < VA_END);
  assign w_en      = w_row_act && (r_h_cnt >= HA) && (r_h_cnt < HA_END);
  // Request window leads the display window by the colour generator's register
  assign w_req     = w_row_act && (r_h_cnt >= REQ_LO) && (r_h_cnt < REQ_HI);

  assign bus.vga_hs      = (r_h_cnt < H_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign bus.vga_vs      = (r_v_cnt < V_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign bus.vga_en      = w_en;
  assign bus.data_req    = w_req;
  assign bus.pixel_xpos  = w_req ? r_h_cnt - REQ_LO : '0;
  assign bus.pixel_ypos  = w_req ? r_v_cnt - VA : '0;
  assign bus.vga_rgb     = w_en ? bus.pixel_data : RGB_W'(0);
  assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_driver.sv
// Bench for vga_driver: default SVGA timing plus a tiny active-low instance,
// each checked every cycle against a cycle-index arithmetic raster model.
module tb_vga_driver;
  localparam int LINE  = 1056;
  localparam int ROW27 = 27 * LINE;
  localparam int ROW28 = 28 * LINE;

  typedef struct {
    logic        hs, vs, en, req, fs;
    logic [10:0] x, y;
    logic [15:0] rgb;
  } exp_t;

  logic vga_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   t       = 0;
  bit   valid   = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 vga_clk = ~vga_clk;

  vga_driver_if bus_d ();
  vga_driver_if bus_s ();

  vga_driver u_dut_d (
    .vga_clk (vga_clk),
    .sys_rst (sys_rst),
    .bus     (bus_d)
  );

  vga_driver #(
    .H_SYNC (11'd2), .H_BACK (11'd2), .H_DISP (11'd4), .H_FRONT (11'd1), .H_TOTAL (11'd9),
    .V_SYNC (11'd1), .V_BACK (11'd1), .V_DISP (11'd3), .V_FRONT (11'd1), .V_TOTAL (11'd6),
    .SYNC_POL (1'b0)
  ) u_dut_s (
    .vga_clk (vga_clk),
    .sys_rst (sys_rst),
    .bus     (bus_s)
  );

  function automatic logic [15:0] colour(input logic [10:0] x, input logic [10:0] y);
    return {x[4:0], y[5:0], 5'b00000};
  endfunction

  // Expected outputs t cycles after the reset edge, straight from the timing rules
  function automatic exp_t model(input int hsw, input int hbp, input int hdp, input int hfp,
                                 input int vsw, input int vbp, input int vdp, input int vfp,
                                 input logic pol, input int tt);
    exp_t e;
    int ht, vt, h, v, ha, va;
    bit rows;
    ht = hsw + hbp + hdp + hfp;
    vt = vsw + vbp + vdp + vfp;
    h  = tt % ht;
    v  = (tt / ht) % vt;
    ha = hsw + hbp;
    va = vsw + vbp;
    rows  = (v >= va) && (v < va + vdp);
    e.hs  = (h < hsw) ? pol : ~pol;
    e.vs  = (v < vsw) ? pol : ~pol;
    e.en  = rows && (h >= ha) && (h < ha + hdp);
    e.req = rows && (h >= ha - 1) && (h < ha + hdp - 1);
    e.x   = e.req ? 11'(h - ha + 1) : 11'd0;
    e.y   = e.req ? 11'(v - va) : 11'd0;
    e.rgb = e.en ? colour(11'(h - ha), 11'(v - va)) : 16'd0;
    e.fs  = (tt >= 1) && (((tt - 1) % (ht * vt)) == 0);
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, t);
  endtask

  task automatic cmp_all(input string tag, input exp_t e,
                         input logic hs, input logic vs, input logic en, input logic req,
                         input logic fs, input logic [10:0] x, input logic [10:0] y,
                         input logic [15:0] rgb);
    check({tag, ".hs"},  int'(hs),  int'(e.hs));
    check({tag, ".vs"},  int'(vs),  int'(e.vs));
    check({tag, ".en"},  int'(en),  int'(e.en));
    check({tag, ".req"}, int'(req), int'(e.req));
    check({tag, ".fs"},  int'(fs),  int'(e.fs));
    check({tag, ".x"},   int'(x),   int'(e.x));
    check({tag, ".y"},   int'(y),   int'(e.y));
    check({tag, ".rgb"}, int'(rgb), int'(e.rgb));
  endtask

  // Cycle index since the last reset edge
  always @(posedge vga_clk) begin
    if (sys_rst) begin
      t     <= 0;
      valid <= 1'b1;
    end else begin
      t <= t + 1;
    end
  end

  // One-register colour sources; white outside requests to prove blanking
  always @(posedge vga_clk) begin
    bus_d.pixel_data <= bus_d.data_req ? colour(bus_d.pixel_xpos, bus_d.pixel_ypos) : 16'hFFFF;
    bus_s.pixel_data <= bus_s.data_req ? colour(bus_s.pixel_xpos, bus_s.pixel_ypos) : 16'hFFFF;
  end

  always @(negedge vga_clk) begin
    if (valid) begin
      cmp_all("dflt", model(128, 88, 800, 40, 4, 23, 600, 1, 1'b1, t),
              bus_d.vga_hs, bus_d.vga_vs, bus_d.vga_en, bus_d.data_req, bus_d.frame_start,
              bus_d.pixel_xpos, bus_d.pixel_ypos, bus_d.vga_rgb);
      cmp_all("small", model(2, 2, 4, 1, 1, 1, 3, 1, 1'b0, t),
              bus_s.vga_hs, bus_s.vga_vs, bus_s.vga_en, bus_s.data_req, bus_s.frame_start,
              bus_s.pixel_xpos, bus_s.pixel_ypos, bus_s.vga_rgb);
    end
  end

  task automatic at(input int target);
    while (t < target) @(negedge vga_clk);
  endtask

  task automatic chk_reset_state(input string tag);
    check({tag, ".hs"},  int'(bus_d.vga_hs), 1);
    check({tag, ".vs"},  int'(bus_d.vga_vs), 1);
    check({tag, ".en"},  int'(bus_d.vga_en), 0);
    check({tag, ".req"}, int'(bus_d.data_req), 0);
    check({tag, ".x"},   int'(bus_d.pixel_xpos), 0);
    check({tag, ".y"},   int'(bus_d.pixel_ypos), 0);
    check({tag, ".rgb"}, int'(bus_d.vga_rgb), 0);
    check({tag, ".fs"},  int'(bus_d.frame_start), 0);
    check({tag, ".s_hs"}, int'(bus_s.vga_hs), 0);
    check({tag, ".s_vs"}, int'(bus_s.vga_vs), 0);
  endtask

  initial begin
    repeat (2) @(posedge vga_clk);
    #1 sys_rst = 1'b0;
    @(negedge vga_clk);

    chk_reset_state("rst0");
    at(1);     check("fs_pulse", int'(bus_d.frame_start), 1);
               check("s_fs_pulse", int'(bus_s.frame_start), 1);
    at(2);     check("fs_drop", int'(bus_d.frame_start), 0);
               check("s_hs_off", int'(bus_s.vga_hs), 1);
    at(9);     check("s_hs_line", int'(bus_s.vga_hs), 0);
               check("s_vs_off", int'(bus_s.vga_vs), 1);
    at(21);    check("s_req0", int'(bus_s.data_req), 1);
               check("s_x0", int'(bus_s.pixel_xpos), 0);
               check("s_y0", int'(bus_s.pixel_ypos), 0);
    at(23);    check("s_rgb1", int'(bus_s.vga_rgb), 16'h0800);
    at(42);    check("s_xlast", int'(bus_s.pixel_xpos), 3);
               check("s_ylast", int'(bus_s.pixel_ypos), 2);
    at(43);    check("s_rgblast", int'(bus_s.vga_rgb), 16'h1840);
    at(44);    check("s_en_off", int'(bus_s.vga_en), 0);
    at(55);    check("s_fs2", int'(bus_s.frame_start), 1);
    at(127);   check("hs_w_end", int'(bus_d.vga_hs), 1);
    at(128);   check("hs_off", int'(bus_d.vga_hs), 0);
    at(LINE);  check("hs_period", int'(bus_d.vga_hs), 1);
    at(4223);  check("vs_w_end", int'(bus_d.vga_vs), 1);
    at(4224);  check("vs_off", int'(bus_d.vga_vs), 0);
    at(26 * LINE + 500);
               check("row26_en", int'(bus_d.vga_en), 0);
               check("row26_req", int'(bus_d.data_req), 0);
    at(ROW27 + 214); check("req_pre", int'(bus_d.data_req), 0);
    at(ROW27 + 215); check("req_first", int'(bus_d.data_req), 1);
                     check("x_first", int'(bus_d.pixel_xpos), 0);
                     check("y_first", int'(bus_d.pixel_ypos), 0);
                     check("en_pre", int'(bus_d.vga_en), 0);
    at(ROW27 + 216); check("en_first", int'(bus_d.vga_en), 1);
    at(ROW27 + 221); check("rgb_x5", int'(bus_d.vga_rgb), 16'h2800);
    at(ROW27 + 1014); check("x_last", int'(bus_d.pixel_xpos), 799);
    at(ROW27 + 1015); check("req_end", int'(bus_d.data_req), 0);
                      check("en_last", int'(bus_d.vga_en), 1);
                      check("rgb_last", int'(bus_d.vga_rgb), 16'hF800);
    at(ROW27 + 1016); check("en_end", int'(bus_d.vga_en), 0);
                      check("rgb_blank", int'(bus_d.vga_rgb), 0);
    at(ROW28 + 215);  check("y_row28", int'(bus_d.pixel_ypos), 1);

    // Mid-frame reset at line 28, pixel 500
    at(ROW28 + 500); check("mid_x", int'(bus_d.pixel_xpos), 285);
                     check("mid_y", int'(bus_d.pixel_ypos), 1);
    sys_rst = 1'b1;
    @(posedge vga_clk);
    #1 sys_rst = 1'b0;
    @(negedge vga_clk);
    chk_reset_state("rst1");
    at(1);           check("fs_after_rst", int'(bus_d.frame_start), 1);
    at(ROW27 + 215); check("req_after_rst", int'(bus_d.data_req), 1);
                     check("x_after_rst", int'(bus_d.pixel_xpos), 0);
    at(ROW27 + 1014); check("xl_after_rst", int'(bus_d.pixel_xpos), 799);
    at(ROW27 + 1100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/vga_driver.md
Name: vga_driver

Overview:
- SVGA timing generator: the raster source that drives the pixel-colour generator (the vga_display block).
- Produces hsync/vsync, the active-video enable, and the pixel coordinate request (pixel_xpos/pixel_ypos), one cycle ahead of display.
- Accepts the registered RGB565 pixel_data returned one cycle later and gates it onto the VGA output pins.
- Also emits a per-frame pulse that the game logic uses to advance snake state.

Parameters:
- H_SYNC, 11'd128, hsync pulse width (pixels)
- H_BACK, 11'd88, horizontal back porch
- H_DISP, 11'd800, horizontal active pixels
- H_FRONT, 11'd40, horizontal front porch
- H_TOTAL, 11'd1056, line period; must equal H_SYNC+H_BACK+H_DISP+H_FRONT
- V_SYNC, 11'd4, vsync width (lines)
- V_BACK, 11'd23, vertical back porch
- V_DISP, 11'd600, vertical active lines
- V_FRONT, 11'd1, vertical front porch
- V_TOTAL, 11'd628, frame period; must equal V_SYNC+V_BACK+V_DISP+V_FRONT
- SYNC_POL, 1'b1, sync active level (1 = active-high, the 800x600@60 standard)

Ports:
- vga_clk  input  1  pixel clock, 40 MHz for defaults; single clock domain
- sys_rst  input  1  synchronous, active-high reset
- pixel_data  input  16  RGB565 colour for the coordinate requested on the previous cycle
- pixel_xpos  output  11  requested column, 0..H_DISP-1, else 0
- pixel_ypos  output  11  requested row, 0..V_DISP-1, else 0
- data_req  output  1  coordinate request valid
- vga_hs  output  1  horizontal sync
- vga_vs  output  1  vertical sync
- vga_en  output  1  active video
- vga_rgb  output  16  RGB565 to DAC
- frame_start  output  1  one-cycle pulse at start of each frame

Behaviour:
- h_cnt (11b) is a register: increments every vga_clk and wraps H_TOTAL-1 -> 0.
- v_cnt (11b) is a register: increments only on the cycle where h_cnt == H_TOTAL-1, and wraps V_TOTAL-1 -> 0 on that same cycle.
- sys_rst high at a clock edge: h_cnt = 0 and v_cnt = 0 next cycle. Reset mid-frame restarts the frame immediately; no partial-line completion.
- Define HA = H_SYNC+H_BACK and VA = V_SYNC+V_BACK.
- All outputs below are decoded from the counter registers (or, for frame_start, registered). There are no other state elements.
- vga_hs = SYNC_POL when h_cnt < H_SYNC, else ~SYNC_POL.
- vga_vs = SYNC_POL when v_cnt < V_SYNC, else ~SYNC_POL.
- vga_en = 1 iff HA <= h_cnt < HA+H_DISP and VA <= v_cnt < VA+V_DISP.
- data_req = 1 iff HA-1 <= h_cnt < HA+H_DISP-1 and VA <= v_cnt < VA+V_DISP.
  - data_req leads vga_en by exactly one cycle, covering the one-register latency of the colour generator.
- pixel_xpos = data_req ? h_cnt-(HA-1) : 0.
- pixel_ypos = data_req ? v_cnt-VA : 0.
- Subtraction is 11-bit unsigned and is only used while data_req=1, so it never underflows.
- vga_rgb = vga_en ? pixel_data : 16'd0. Blanking is forced black regardless of pixel_data.
- frame_start is a registered output: it is 1 for the single cycle after h_cnt==0 && v_cnt==0, else 0.
- Reset values of outputs:
  - In the reset cycle and the first cycle after: h_cnt=v_cnt=0, so vga_hs = vga_vs = SYNC_POL, vga_en = 0, data_req = 0, pixel_xpos = pixel_ypos = 0, vga_rgb = 0.
  - frame_start = 0 while sys_rst is high.
- Simultaneous line and frame wrap (h=H_TOTAL-1, v=V_TOTAL-1): both counters go to 0 on the same edge.
- Parameters are static; no runtime mode change.
- Line and frame boundaries:
  - Last request of a line: xpos = H_DISP-1, at h_cnt = HA+H_DISP-2.
  - Last active line: ypos = V_DISP-1.
  - No requests are issued on any line outside the active rows.

Test Plan:
- Reset then run 2 lines -> hs low-to-high period 1056 cycles, high width 128; data_req 800 cycles/line only on v_cnt 27..626; vga_en=0 on lines 0..26.
- Full frame with defaults -> vs high for exactly 4*1056 = 4224 cycles; frame period 663168 cycles; frame_start exactly one pulse per frame, 1 cycle after h=v=0.
- First active line: data_req rises at h_cnt=215 with xpos=0, ypos=0; vga_en rises at h_cnt=216. Model a 1-cycle-register colour source returning {xpos[4:0], ypos[5:0], 5'b0} -> vga_rgb matches the coordinate requested one cycle earlier for all 800 pixels.
- Last pixel: xpos=799, ypos=599 requested at h=1014; vga_en falls after h=1015; vga_rgb=0 whenever vga_en=0 with pixel_data=16'hFFFF.
- Assert sys_rst for 1 cycle at v_cnt=300, h_cnt=500 -> next cycle h=v=0, vga_en=0, data_req=0, hs=vs=1; timing thereafter is identical to post-power-up.
- Small params (H 2/2/4/1, V 1/1/3/1, SYNC_POL=0) -> hs/vs active-low; H_TOTAL=9, V_TOTAL=6 wrap verified exhaustively over 3 frames against a reference model.
